mem_target: RTL and testbench

Single-port program/data memory that responds to the CPU controller's bus strobes. It is the target end of the controller's `sel`/`rd`/`wr`/`data_e` bus. It returns read data with a fixed, parameterised latency and commits exactly one write per `wr` pulse. It also flags protocol violations and provides a preload port so a testbench or boot loader can fill the program image while the bus is idle.

---
 rtl/mem_target.sv | 161 ++++++++++++++++
 tb/tb_mem_target.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_target.sv
// Single-port program/data memory acting as the bus target of the CPU controller.
// Fixed-latency reads, one commit per write pulse, sticky protocol-error flag, idle-time preload port.
module mem_target #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_vld,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic              err_clr,
  output logic              bus_err
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = 2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2,
    WR_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [AWIDTH-1:0]   r_addr_q;
  logic [AWIDTH-1:0]   w_addr_q_nxt;
  logic                r_data_vld;
  logic                w_data_vld_nxt;
  logic [DWIDTH-1:0]   r_data_out;
  logic                r_bus_err;
  logic                w_load_dout;
  logic                w_err_set;
  logic                w_mem_we;
  logic [AWIDTH-1:0]   w_mem_addr;
  logic [DWIDTH-1:0]   w_mem_din;
  logic [DWIDTH-1:0]   r_mem [DEPTH];

  // Preload only when no bus strobe is pending; a strobe always wins the port.
  assign ld_ready = (r_state == IDLE) && !rd && !wr;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_q_nxt   = r_addr_q;
    w_data_vld_nxt = r_data_vld;
    w_load_dout    = 1'b0;
    w_err_set      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = addr;
    w_mem_din      = data_in;
    case (r_state)
      IDLE: begin
        if (rd && wr) begin
          w_err_set = 1'b1;
        end else if (rd) begin
          w_addr_q_nxt = addr;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = RD_WAIT;
        end else if (wr) begin
          w_mem_we    = 1'b1;
          w_state_nxt = WR_HOLD;
        end else if (ld_valid) begin
          w_mem_we   = 1'b1;
          w_mem_addr = ld_addr;
          w_mem_din  = ld_data;
        end
      end
      RD_WAIT: begin
        if (!rd) begin
          w_state_nxt = IDLE;
        end else if (wr) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end else if (addr != r_addr_q) begin
          w_addr_q_nxt = addr;
          w_cnt_nxt    = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_load_dout    = 1'b1;
          w_data_vld_nxt = 1'b1;
          w_state_nxt    = RD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RD_HOLD: begin
        // A write during a read is flagged even if the address also moved.
        if (!rd) begin
          w_data_vld_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end else if (wr) begin
          w_err_set      = 1'b1;
          w_data_vld_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end else if (addr != r_addr_q) begin
          w_data_vld_nxt = 1'b0;
          w_addr_q_nxt   = addr;
          w_cnt_nxt      = CNT_LOAD;
          w_state_nxt    = RD_WAIT;
        end
      end
      WR_HOLD: begin
        if (!wr) begin
          w_state_nxt = IDLE;
        end else if (rd) begin
          w_err_set = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr_q   <= '0;
      r_data_vld <= 1'b0;
      r_data_out <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_q   <= w_addr_q_nxt;
      r_data_vld <= w_data_vld_nxt;
      if (w_load_dout) begin
        r_data_out <= r_mem[r_addr_q];
      end
      if (w_err_set) begin
        r_bus_err <= 1'b1;
      end else if (err_clr) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  // Array is never reset; the write is gated so nothing commits while reset is held.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst_n) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  assign data_out = r_data_out;
  assign data_vld = r_data_vld;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_target.sv
// Directed bench for mem_target: one instance at RD_LAT=1 and one at RD_LAT=2 on a shared bus.
module tb_mem_target;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] addr;
  logic       rd, wr;
  logic [7:0] data_in;
  logic       ld_valid;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       err_clr;

  logic [7:0] dout1, dout2;
  logic       vld1, vld2, ldr1, ldr2, err1, err2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_target #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout1), .data_vld(vld1), .ld_valid(ld_valid), .ld_ready(ldr1),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_clr(err_clr), .bus_err(err1)
  );

  mem_target #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout2), .data_vld(vld2), .ld_valid(ld_valid), .ld_ready(ldr2),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_clr(err_clr), .bus_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; err_clr = 1'b0;
    #3;
    check("rst_data_out", 32'(dout1), 32'h00);
    check("rst_data_vld", 32'(vld1), 32'd0);
    check("rst_bus_err", 32'(err1), 32'd0);
    check("rst_ld_ready", 32'(ldr1), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back preloads: mem[3]=A5, mem[4]=11, mem[5]=22
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 8'hA5; tick();
    ld_addr = 5'd4; ld_data = 8'h11; tick();
    ld_addr = 5'd5; ld_data = 8'h22; tick();
    ld_valid = 1'b0;

    // Read addr 3, RD_LAT=1, rd high for 3 cycles
    rd = 1'b1; addr = 5'd3;
    tick();
    check("rd3_vld_edgeN", 32'(vld1), 32'd0);
    tick();
    check("rd3_vld_edgeN1", 32'(vld1), 32'd1);
    check("rd3_data", 32'(dout1), 32'hA5);
    tick();
    check("rd3_vld_hold", 32'(vld1), 32'd1);
    check("rd3_lat2_vld", 32'(vld2), 32'd1);
    check("rd3_lat2_data", 32'(dout2), 32'hA5);
    rd = 1'b0;
    tick();
    check("rd3_vld_fall", 32'(vld1), 32'd0);
    check("rd3_data_kept", 32'(dout1), 32'hA5);
    check("rd3_ld_ready", 32'(ldr1), 32'd1);

    // Single commit per write pulse
    wr = 1'b1; addr = 5'd7; data_in = 8'h3C;
    #1;
    check("wr_ld_ready_low", 32'(ldr1), 32'd0);
    tick(); tick();
    data_in = 8'hFF;
    tick();
    wr = 1'b0;
    tick();
    rd = 1'b1;
    tick(); tick();
    check("rd7_vld", 32'(vld1), 32'd1);
    check("rd7_single_commit", 32'(dout1), 32'h3C);
    check("wr_no_err", 32'(err1), 32'd0);
    rd = 1'b0;
    tick();

    // rd and wr together in IDLE
    rd = 1'b1; wr = 1'b1; addr = 5'd7; data_in = 8'h55;
    #1;
    check("err_ld_ready", 32'(ldr1), 32'd0);
    tick();
    check("err_set", 32'(err1), 32'd1);
    check("err_set_lat2", 32'(err2), 32'd1);
    err_clr = 1'b1;
    tick();
    check("err_set_beats_clr", 32'(err1), 32'd1);
    rd = 1'b0; wr = 1'b0;
    tick();
    check("err_cleared", 32'(err1), 32'd0);
    err_clr = 1'b0;
    rd = 1'b1;
    tick(); tick();
    check("err_mem_unchanged", 32'(dout1), 32'h3C);
    rd = 1'b0;
    tick();

    // RD_LAT=2, address moves from 4 to 5 one cycle into RD_WAIT
    rd = 1'b1; addr = 5'd4;
    tick();
    addr = 5'd5;
    tick();
    check("lat2_chg_edge0", 32'(vld2), 32'd0);
    tick();
    check("lat2_chg_edge1", 32'(vld2), 32'd0);
    tick();
    check("lat2_chg_edge2_vld", 32'(vld2), 32'd1);
    check("lat2_chg_data", 32'(dout2), 32'h22);
    check("lat2_chg_no_err", 32'(err2), 32'd0);
    rd = 1'b0;
    tick();

    // Reset pulse during RD_HOLD, with a write attempted while reset is held
    rd = 1'b1; addr = 5'd3;
    tick(); tick();
    check("pre_rst_vld", 32'(vld1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld", 32'(vld1), 32'd0);
    check("rst_mid_data", 32'(dout1), 32'h00);
    rd = 1'b0; wr = 1'b1; data_in = 8'hEE;
    tick();
    wr = 1'b0; rst_n = 1'b1;
    tick();
    rd = 1'b1;
    tick(); tick();
    check("post_rst_vld", 32'(vld1), 32'd1);
    check("post_rst_no_commit", 32'(dout1), 32'hA5);
    rd = 1'b0;
    tick();

    // Preload held off by an active read, then commits once
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 8'h77;
    rd = 1'b1; addr = 5'd3;
    #1;
    check("ld_held_ready", 32'(ldr1), 32'd0);
    tick(); tick(); tick();
    check("ld_held_rd_data", 32'(dout2), 32'hA5);
    check("ld_held_rd_data1", 32'(dout1), 32'hA5);
    rd = 1'b0;
    #1;
    check("ld_ready_in_hold", 32'(ldr1), 32'd0);
    tick();
    check("ld_ready_after_rd", 32'(ldr1), 32'd1);
    tick();
    ld_valid = 1'b0;
    rd = 1'b1;
    tick(); tick();
    check("ld_commit_data", 32'(dout1), 32'h77);
    check("ld_no_err", 32'(err1), 32'd0);
    rd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
